mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter and output register for a shared 2:1 4-bit mux datapath.
//   Two sources offer packets (valid/ready/last); the arbiter grants one source per packet.
//   It drives the mux select and registers the mux output into a single-entry output stage.
//   Sits between the two Project B data producers and the single downstream consumer.
// PARAMETERS
//   WIDTH    4   data width of each source and of the output
//   TIMEOUT  16  idle cycles before a held grant is revoked (used only with ARB_TIMEOUT_EN)
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   src0_valid   in   1      source 0 has a beat
//   src0_data    in   WIDTH  source 0 beat data
//   src0_last    in   1      source 0 beat is the last beat of its packet
//   src0_ready   out  1      source 0 beat accepted this cycle
//   src1_valid   in   1      source 1 has a beat
//   src1_data    in   WIDTH  source 1 beat data
//   src1_last    in   1      source 1 beat is the last beat of its packet
//   src1_ready   out  1      source 1 beat accepted this cycle
//   out_valid    out  1      output register holds a beat
//   out_data     out  WIDTH  registered beat
//   out_last     out  1      registered last flag
//   out_ready    in   1      consumer accepts the output beat
//   mux_sel      out  1      1 = source 0 drives mux, 0 = source 1
//   grant        out  2      one-hot owner {src1,src0}; 2'b00 when idle
// BEHAVIOUR
//   - Clock domain: one clock; reset is asynchronous and active-low (rst_n).
//   - Reset: state=IDLE, out_valid=0, out_data=0, out_last=0, grant=00, mux_sel=1, prio pointer=src0.
//   - Handshake: a beat transfers on src*_valid && src*_ready. Output register load enable:
//     ld = !out_valid || out_ready. src_i_ready = ld && (state grants i), combinational.
//   - FSM IDLE:
//     - No valid: stay.
//     - One valid: grant it.
//     - Both valid: grant the source named by the prio pointer.
//     - The grant is combinational in the same cycle, so a beat can load immediately.
//     - Next state OWN0/OWN1, unless the accepted beat has last=1 (single-beat packet):
//       then stay IDLE and flip the pointer.
//   - FSM OWNi: only source i may transfer; the other source's ready is 0.
//     - Accepted beat with last=1: go to IDLE and set the pointer to the other source.
//     - OWNi with src_i_valid=0: hold the grant and emit nothing.
//   - Latency: an accepted beat appears on out_* the next cycle. Full throughput is
//     1 beat/cycle while out_ready=1.
//   - Backpressure: out_valid=1 && out_ready=0 holds out_* stable and forces both src readys to 0.
//   - Simultaneous out_ready and a new accept: the register reloads with no bubble.
//   - mux_sel follows the grant. It holds its last value while IDLE with no request.
//   - Async reset mid-packet drops the packet: state returns to IDLE and the output is cleared.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - In OWNi a counter increments each cycle src_i_valid=0 and clears on any src_i_valid.
//     - When the counter reaches TIMEOUT-1, go to IDLE and flip the pointer; the packet is
//       truncated with no last emitted.
//     - Counter width is $clog2(TIMEOUT).
//   ARB_TIMEOUT_EN undefined: no counter; the grant is held indefinitely until last.
// STRUCTURE
//   - Shared package mux_arb_pkg:
//     - state enum {IDLE, OWN0, OWN1}
//     - localparam SEL_SRC0=1'b1, SEL_SRC1=1'b0
//   - Sub-module mux2_w: the parameterised WIDTH+1 bit 2:1 mux (data+last), sel=1 picks input 0.
//   - The arbiter FSM and output register live in this module.
// TESTING
//   1. Reset then src0 single beat (data=4'hA, last=1), out_ready=1:
//      src0_ready=1 in the same cycle; next cycle out_valid=1, out_data=A, out_last=1; pointer -> src1.
//   2. Both valid from IDLE after reset, each a 3-beat packet (src0 1,2,3; src1 7,8,9):
//      out stream 1,2,3,7,8,9 with no gap; src1_ready stays 0 during the src0 packet.
//   3. Both sources stream 1-beat packets continuously: grants alternate 01,10,01,10;
//      mux_sel toggles each cycle.
//   4. out_ready=0 for 3 cycles with out_valid=1: out_data stable, both readys 0;
//      on release no beat is lost or duplicated.
//   5. Assert rst_n low in the middle of an OWN1 packet: out_valid=0 and grant=00 at once;
//      after release src0 wins first arbitration.
//   6. ARB_TIMEOUT_EN, TIMEOUT=16: OWN0 with src0 idle for 16 cycles -> IDLE, then pending
//      src1 granted; without the macro the grant is still held at cycle 100.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared arbiter state encoding and mux select polarity for mux_rr_arbiter
package mux_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
   localparam logic SEL_SRC0 = 1'b1;
   localparam logic SEL_SRC1 = 1'b0;
endpackage

// File: rtl/mux2_w.sv
// mux2_w: W-bit 2:1 mux; sel_i=SEL_SRC0 picks in0_i, otherwise in1_i
//   sel_i  in  1  select
//   in0_i  in  W  input 0 (source 0)
//   in1_i  in  W  input 1 (source 1)
//   out_o  out W  selected input
module mux2_w
   import mux_arb_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         sel_i,
   input  logic [W-1:0] in0_i,
   input  logic [W-1:0] in1_i,
   output logic [W-1:0] out_o
);
   assign out_o = (sel_i == SEL_SRC0) ? in0_i : in1_i;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: packet round-robin arbiter over two sources feeding a registered 2:1 mux
//   clk, rst_n                      clock, async active-low reset
//   src{0,1}_valid/_data/_last      source beats in
//   src{0,1}_ready                  combinational accept per source
//   out_valid/_data/_last, out_ready single-entry output register to the consumer
//   mux_sel                         1 = source 0 drives the mux
//   grant                           one-hot owner {src1,src0}, 00 when idle
//   Optional: ARB_TIMEOUT_EN revokes a grant after TIMEOUT idle cycles of the owner
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             src0_valid,
   input  logic [WIDTH-1:0] src0_data,
   input  logic             src0_last,
   output logic             src0_ready,
   input  logic             src1_valid,
   input  logic [WIDTH-1:0] src1_data,
   input  logic             src1_last,
   output logic             src1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             mux_sel,
   output logic [1:0]       grant
);
   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             sel_q;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic             g0, g1, ld, acc0, acc1;
   logic [WIDTH:0]   mux_out;
`ifdef ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             own_valid;
`endif
   // ptr_q=0 gives source 0 priority on a tie in IDLE
   assign g0         = (state_q == OWN0) || (state_q == IDLE && src0_valid && (!src1_valid || !ptr_q));
   assign g1         = (state_q == OWN1) || (state_q == IDLE && src1_valid && (!src0_valid || ptr_q));
   assign grant      = {g1, g0};
   assign ld         = !out_valid_q || out_ready;
   assign src0_ready = ld && g0;
   assign src1_ready = ld && g1;
   assign acc0       = src0_valid && src0_ready;
   assign acc1       = src1_valid && src1_ready;
   assign mux_sel    = g0 ? SEL_SRC0 : g1 ? SEL_SRC1 : sel_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   mux2_w #(.W(WIDTH + 1)) u_mux (
      .sel_i (mux_sel),
      .in0_i ({src0_last, src0_data}),
      .in1_i ({src1_last, src1_data}),
      .out_o (mux_out)
   );
`ifdef ARB_TIMEOUT_EN
   assign own_valid = (state_q == OWN0) ? src0_valid : src1_valid;
`endif
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_valid_d = ld ? (acc0 || acc1) : out_valid_q;
      out_data_d  = (acc0 || acc1) ? mux_out[WIDTH-1:0] : out_data_q;
      out_last_d  = (acc0 || acc1) ? mux_out[WIDTH] : out_last_q;
      if (acc0 || acc1) begin
         // a last beat releases the grant and hands priority to the other source
         state_d = mux_out[WIDTH] ? IDLE : (acc0 ? OWN0 : OWN1);
         ptr_d   = mux_out[WIDTH] ? acc0 : ptr_q;
      end
`ifdef ARB_TIMEOUT_EN
      cnt_d = '0;
      if (state_q != IDLE && !own_valid) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ptr_d   = (state_q == OWN0);
            cnt_d   = '0;
         end
      end
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         sel_q       <= SEL_SRC0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= mux_sel;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: vector table, directed corner sequences and a randomized run against a packet-level model
module tb_mux_rr_arbiter;
   localparam int TIMEOUT = 16;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       src0_valid, src0_last, src0_ready;
   logic       src1_valid, src1_last, src1_ready;
   logic [3:0] src0_data, src1_data, out_data;
   logic       out_valid, out_last, out_ready, mux_sel;
   logic [1:0] grant;
   int         n_pass = 0;
   int         n_tot = 0;
   typedef struct {
      logic v0; logic [3:0] d0; logic l0;
      logic v1; logic [3:0] d1; logic l1;
      logic ordy;
      logic r0; logic r1; logic [1:0] g; logic sel;
      logic ov; logic [3:0] od; logic ol;
   } vec_t;
   vec_t tbl[8];
   mux_rr_arbiter #(.WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .src0_valid(src0_valid), .src0_data(src0_data), .src0_last(src0_last), .src0_ready(src0_ready),
      .src1_valid(src1_valid), .src1_data(src1_data), .src1_last(src1_last), .src1_ready(src1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .mux_sel(mux_sel), .grant(grant)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic drive(input logic v0, input logic [3:0] d0, input logic l0,
                        input logic v1, input logic [3:0] d1, input logic l1, input logic ordy);
      src0_valid = v0; src0_data = d0; src0_last = l0;
      src1_valid = v1; src1_data = d1; src1_last = l1;
      out_ready = ordy;
   endtask
   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_grant", grant, 0);
      chk("rst_mux_sel", mux_sel, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask
   initial begin
      int   i0, i1, owner, prio, idle_run, gnt;
      logic m_ov, m_ol, m_sel, ldm, acc, esel;
      logic [3:0] m_od;
      logic [1:0] eg;
      logic vv[2], ll[2], pres[2];
      logic [3:0] dd[2];
      int   rem[2];
      logic [3:0] got[$];
      logic [3:0] s0[3];
      logic [3:0] s1[3];
      logic [3:0] want[6];
      logic       ordy_pat[9];
      tbl[0] = '{1, 4'hA, 1, 0, 4'h0, 0, 1, 1, 0, 2'b01, 1, 0, 4'h0, 0};
      tbl[1] = '{0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 2'b00, 1, 1, 4'hA, 1};
      tbl[2] = '{1, 4'h3, 1, 1, 4'h5, 1, 1, 0, 1, 2'b10, 0, 0, 4'h0, 0};
      tbl[3] = '{1, 4'h3, 1, 1, 4'h6, 1, 1, 1, 0, 2'b01, 1, 1, 4'h5, 1};
      tbl[4] = '{1, 4'h4, 1, 1, 4'h6, 1, 1, 0, 1, 2'b10, 0, 1, 4'h3, 1};
      tbl[5] = '{0, 4'h0, 0, 1, 4'h7, 1, 1, 0, 1, 2'b10, 0, 1, 4'h6, 1};
      tbl[6] = '{0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 2'b00, 0, 1, 4'h7, 1};
      tbl[7] = '{0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 2'b00, 0, 0, 4'h0, 0};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(tbl[k].v0, tbl[k].d0, tbl[k].l0, tbl[k].v1, tbl[k].d1, tbl[k].l1, tbl[k].ordy);
         @(negedge clk);
         chk($sformatf("vec%0d_src0_ready", k), src0_ready, tbl[k].r0);
         chk($sformatf("vec%0d_src1_ready", k), src1_ready, tbl[k].r1);
         chk($sformatf("vec%0d_grant", k), grant, tbl[k].g);
         chk($sformatf("vec%0d_mux_sel", k), mux_sel, tbl[k].sel);
         chk($sformatf("vec%0d_out_valid", k), out_valid, tbl[k].ov);
         if (tbl[k].ov) begin
            chk($sformatf("vec%0d_out_data", k), out_data, tbl[k].od);
            chk($sformatf("vec%0d_out_last", k), out_last, tbl[k].ol);
         end
         @(posedge clk); #1;
      end
      // two 3-beat packets offered together: src0 first, then src1, no gap
      do_reset();
      s0 = '{4'h1, 4'h2, 4'h3};
      s1 = '{4'h7, 4'h8, 4'h9};
      want = '{4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9};
      i0 = 0; i1 = 0; got.delete();
      for (int c = 0; c < 8; c++) begin
         drive(i0 < 3, (i0 < 3) ? s0[i0] : 4'h0, i0 == 2, i1 < 3, (i1 < 3) ? s1[i1] : 4'h0, i1 == 2, 1);
         @(negedge clk);
         if (i0 < 3) chk("pkt_src1_blocked", src1_ready, 0);
         if (c >= 1 && c <= 6) chk("pkt_no_gap", out_valid, 1);
         if (out_valid) got.push_back(out_data);
         if (src0_valid && src0_ready) i0++;
         if (src1_valid && src1_ready) i1++;
         @(posedge clk); #1;
      end
      chk("pkt_count", got.size(), 6);
      for (int k = 0; k < 6 && k < got.size(); k++) chk($sformatf("pkt_beat%0d", k), got[k], want[k]);
      // backpressure: out_ready low for 3 cycles while holding a beat
      do_reset();
      s0 = '{4'h4, 4'h5, 4'h6};
      ordy_pat = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
      i0 = 0; got.delete();
      for (int c = 0; c < 9; c++) begin
         drive(i0 < 3, (i0 < 3) ? s0[i0] : 4'h0, i0 == 2, 1, 4'hE, 1, ordy_pat[c]);
         @(negedge clk);
         if (c >= 1 && c <= 3) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 4'h4);
            chk("bp_src0_ready", src0_ready, 0);
            chk("bp_src1_ready", src1_ready, 0);
         end
         if (out_valid && out_ready && out_data != 4'hE) got.push_back(out_data);
         if (src0_valid && src0_ready) i0++;
         @(posedge clk); #1;
      end
      chk("bp_count", got.size(), 3);
      for (int k = 0; k < 3 && k < got.size(); k++) chk($sformatf("bp_beat%0d", k), got[k], s0[k]);
      // async reset in the middle of a src1 packet
      do_reset();
      drive(0, 0, 0, 1, 4'h7, 0, 1);
      @(posedge clk); #1;
      drive(1, 4'h2, 1, 1, 4'h8, 0, 1);
      @(negedge clk);
      chk("ar_own1_src0_blocked", src0_ready, 0);
      @(posedge clk); #2;
      chk("ar_pre_out_valid", out_valid, 1);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_grant", grant, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(1, 4'h1, 1, 1, 4'h9, 1, 1);
      @(negedge clk);
      chk("ar_first_grant", grant, 2'b01);
      @(posedge clk); #1;
      // idle owner: timeout revokes after TIMEOUT cycles, otherwise grant is held
      do_reset();
      drive(1, 4'h1, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("to_start_grant", grant, 2'b01);
      @(posedge clk); #1;
      drive(0, 0, 0, 1, 4'h2, 1, 1);
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
`ifdef ARB_TIMEOUT_EN
         if (c <= TIMEOUT) chk("to_hold", grant, 2'b01);
         else if (c == TIMEOUT + 1) chk("to_revoked", grant, 2'b10);
`else
         if (c == TIMEOUT + 1 || c == 100) chk("to_held", grant, 2'b01);
         if (c == 100) chk("to_src1_blocked", src1_ready, 0);
`endif
         @(posedge clk); #1;
      end
      // randomized traffic against a packet-level reference
      do_reset();
      owner = -1; prio = 0; idle_run = 0;
      m_ov = 0; m_ol = 0; m_od = 0; m_sel = 1;
      for (int s = 0; s < 2; s++) begin
         pres[s] = 0; rem[s] = $urandom_range(1, 4); dd[s] = 0; ll[s] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int s = 0; s < 2; s++) begin
            if (!pres[s] && $urandom_range(0, 3) != 0) begin
               pres[s] = 1; dd[s] = 4'($urandom); ll[s] = (rem[s] == 1);
            end
            vv[s] = pres[s];
         end
         drive(vv[0], dd[0], ll[0], vv[1], dd[1], ll[1], $urandom_range(0, 3) != 0);
         @(negedge clk);
         ldm  = !m_ov || out_ready;
         gnt  = (owner >= 0) ? owner : (vv[0] && vv[1]) ? prio : vv[0] ? 0 : vv[1] ? 1 : -1;
         eg   = (gnt == 0) ? 2'b01 : (gnt == 1) ? 2'b10 : 2'b00;
         esel = (gnt == 0) ? 1'b1 : (gnt == 1) ? 1'b0 : m_sel;
         chk("rnd_grant", grant, eg);
         chk("rnd_mux_sel", mux_sel, esel);
         chk("rnd_src0_ready", src0_ready, ldm && gnt == 0);
         chk("rnd_src1_ready", src1_ready, ldm && gnt == 1);
         chk("rnd_out_valid", out_valid, m_ov);
         if (m_ov) begin
            chk("rnd_out_data", out_data, m_od);
            chk("rnd_out_last", out_last, m_ol);
         end
         m_sel = esel;
         acc = (gnt >= 0) && vv[gnt] && ldm;
         if (acc) begin
            m_ov = 1; m_od = dd[gnt]; m_ol = ll[gnt];
            owner = ll[gnt] ? -1 : gnt;
            if (ll[gnt]) prio = 1 - gnt;
            pres[gnt] = 0;
            rem[gnt]  = ll[gnt] ? $urandom_range(1, 4) : rem[gnt] - 1;
         end else if (ldm) m_ov = 0;
`ifdef ARB_TIMEOUT_EN
         if (!acc && owner >= 0 && !vv[owner]) begin
            idle_run++;
            if (idle_run == TIMEOUT) begin
               prio = 1 - owner; owner = -1; idle_run = 0;
            end
         end else idle_run = 0;
`endif
         @(posedge clk); #1;
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
